// File: rtl/data_break_arbiter_if.sv
// Requester-side bus of the data-break arbiter.
//   req    : per-requester transfer request (level)
//   wr     : per-requester direction, 1 = device writes memory
//   addr   : packed 15-bit addresses, requester i at [15i+14:15i]
//   wdata  : packed 12-bit write data, requester i at [12i+11:12i]
//   gnt    : one-hot, high while a requester owns the channel
//   done   : one-cycle completion pulse
//   error  : one-cycle timeout pulse
//   rdata  : word read from memory, valid with done
// master = requester side, slave = arbiter side.
interface data_break_arbiter_if #(
  parameter int unsigned NREQ = 2
);
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    wr;
  logic [15*NREQ-1:0] addr;
  logic [12*NREQ-1:0] wdata;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    done;
  logic [NREQ-1:0]    error;
  logic [11:0]        rdata;

  modport master (
    output req, wr, addr, wdata,
    input  gnt, done, error, rdata
  );

  modport slave (
    input  req, wr, addr, wdata,
    output gnt, done, error, rdata
  );
endinterface

// File: rtl/data_break_arbiter.sv
// Shares the CPU data-break (DMA) channel between NREQ requesters.
// Requests are granted one at a time, round-robin. The granted request's
// address, write data and direction are latched toward the CPU, data_break
// is raised, and the arbiter waits for the CPU to reach major state DB2.
// A watchdog aborts a break that has not reached DB2 after TIMEOUT cycles.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   clear          : IOCLR, same effect as reset on arbiter state
//   state          : CPU major state
//   bus            : requester-side interface (slave modport)
//   data_break     : break request to the CPU
//   to_disk        : break direction (1 = device writes memory)
//   dmaAddr        : break address
//   dmaDOUT        : break write data
//   dmaDIN         : memory data from the CPU
module data_break_arbiter #(
  parameter int unsigned NREQ    = 2,
  parameter logic [4:0]  DB2     = 5'd0,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic [4:0]                 state,
  data_break_arbiter_if.slave        bus,
  output logic                       data_break,
  output logic                       to_disk,
  output logic [14:0]                dmaAddr,
  output logic [11:0]                dmaDOUT,
  input  logic [11:0]                dmaDIN
);

  localparam int unsigned IW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [9:0]  TMO = 10'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BREAK,
    S_XFER
  } fsm_t;

  fsm_t            fsm;
  logic [IW-1:0]   rr;
  logic [IW-1:0]   owner;
  logic [IW-1:0]   owner_next;
  logic [IW-1:0]   pick;
  logic            any_req;
  logic [9:0]      count;
  logic [14:0]     sel_addr;
  logic [11:0]     sel_wdata;
  logic            sel_wr;
  logic [NREQ-1:0] pick_onehot;

  // Round-robin search: first requester with req high, starting at rr and
  // wrapping modulo NREQ.
  always_comb begin
    int unsigned   idx;
    logic [IW-1:0] idx_l;
    pick    = '0;
    any_req = 1'b0;
    idx     = 0;
    idx_l   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = int'(rr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      idx_l = IW'(idx);
      if (!any_req && bus.req[idx_l]) begin
        any_req = 1'b1;
        pick    = idx_l;
      end
    end
  end

  always_comb begin
    sel_addr    = '0;
    sel_wdata   = '0;
    sel_wr      = 1'b0;
    pick_onehot = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (pick == IW'(i)) begin
        sel_addr       = bus.addr[i*15 +: 15];
        sel_wdata      = bus.wdata[i*12 +: 12];
        sel_wr         = bus.wr[i];
        pick_onehot[i] = 1'b1;
      end
    end
  end

  assign owner_next = (owner == IW'(NREQ - 1)) ? '0 : owner + 1'b1;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      fsm        <= S_IDLE;
      rr         <= '0;
      owner      <= '0;
      count      <= '0;
      bus.gnt    <= '0;
      bus.done   <= '0;
      bus.error  <= '0;
      bus.rdata  <= '0;
      data_break <= 1'b0;
      to_disk    <= 1'b0;
      dmaAddr    <= '0;
      dmaDOUT    <= '0;
    end else begin
      bus.done  <= '0;
      bus.error <= '0;
      unique case (fsm)
        S_IDLE: begin
          if (any_req) begin
            owner      <= pick;
            bus.gnt    <= pick_onehot;
            dmaAddr    <= sel_addr;
            dmaDOUT    <= sel_wdata;
            to_disk    <= sel_wr;
            data_break <= 1'b1;
            count      <= '0;
            fsm        <= S_BREAK;
          end
        end
        S_BREAK: begin
          if (count != TMO) count <= count + 1'b1;
          // DB2 takes priority over the watchdog in the same cycle.
          if (state == DB2) begin
            data_break <= 1'b0;
            fsm        <= S_XFER;
          end else if (count == TMO) begin
            data_break <= 1'b0;
            bus.gnt    <= '0;
            bus.error  <= bus.gnt;
            rr         <= owner_next;
            fsm        <= S_IDLE;
          end
        end
        S_XFER: begin
          if (!to_disk) bus.rdata <= dmaDIN;
          bus.done <= bus.gnt;
          bus.gnt  <= '0;
          to_disk  <= 1'b0;
          rr       <= owner_next;
          fsm      <= S_IDLE;
        end
        default: fsm <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_break_arbiter.sv
module tb_data_break_arbiter;

  localparam int         N    = 3;
  localparam int         TMO  = 8;
  localparam logic [4:0] DB2C = 5'd10;
  localparam int         NCYC = 3000;

  logic        clk = 1'b0;
  logic        reset, clear;
  logic [4:0]  state;
  logic        data_break, to_disk;
  logic [14:0] dmaAddr;
  logic [11:0] dmaDOUT, dmaDIN;

  data_break_arbiter_if #(.NREQ(N)) bus ();

  data_break_arbiter #(.NREQ(N), .DB2(DB2C), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .clear(clear), .state(state), .bus(bus),
    .data_break(data_break), .to_disk(to_disk), .dmaAddr(dmaAddr),
    .dmaDOUT(dmaDOUT), .dmaDIN(dmaDIN)
  );

  always #5 clk = ~clk;

  typedef struct { int id; logic [14:0] a; logic [11:0] d; logic w; } gnt_t;
  typedef struct { int id; logic err; logic [11:0] rd; } cmp_t;

  gnt_t gq[$];
  cmp_t cq[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Requester state driven by the stimulus process
  logic [N-1:0] rq;
  logic [14:0]  ra  [N];
  logic [11:0]  rwd [N];
  logic         rwr [N];

  task automatic newreq(input int i);
    rq[i]  = 1'b1;
    ra[i]  = 15'($urandom);
    rwd[i] = 12'($urandom);
    rwr[i] = 1'($urandom_range(0, 1));
  endtask

  task automatic drive_bus();
    bus.req = rq;
    for (int i = 0; i < N; i++) begin
      bus.wr[i]             = rwr[i];
      bus.addr[i*15 +: 15]  = ra[i];
      bus.wdata[i*12 +: 12] = rwd[i];
    end
  endtask

  // Stimulus + transaction-level reference model
  initial begin
    int free_at, own, db2_at, clear_at, mrr, w, r, k, idx, s;
    logic [11:0] din_exp, last_rd, rd;
    reset = 1'b1; clear = 1'b0; state = '0; dmaDIN = '0;
    rq = '0;
    for (int i = 0; i < N; i++) begin ra[i] = '0; rwd[i] = '0; rwr[i] = 1'b0; end
    drive_bus();
    repeat (3) @(negedge clk);
    chk("reset_gnt", 32'(bus.gnt), 0);
    chk("reset_done", 32'(bus.done), 0);
    chk("reset_error", 32'(bus.error), 0);
    chk("reset_rdata", 32'(bus.rdata), 0);
    chk("reset_data_break", 32'(data_break), 0);
    chk("reset_to_disk", 32'(to_disk), 0);
    chk("reset_dmaAddr", 32'(dmaAddr), 0);
    chk("reset_dmaDOUT", 32'(dmaDOUT), 0);
    reset = 1'b0;
    free_at = 0; own = -1; db2_at = -1; clear_at = -1; mrr = 0;
    din_exp = '0; last_rd = '0;

    for (int t = 0; t < NCYC + 150; t++) begin
      bit gen;
      gen = (t < NCYC);
      if (clear_at >= 0 && t == clear_at + 1) begin
        chk("clear_data_break", 32'(data_break), 0);
        chk("clear_gnt", 32'(bus.gnt), 0);
        chk("clear_to_disk", 32'(to_disk), 0);
        chk("clear_done_error", 32'({bus.done, bus.error}), 0);
        chk("clear_rdata", 32'(bus.rdata), 0);
        clear_at = -1;
      end
      // Served requester decides whether to re-request in its done cycle.
      if (t == free_at && own >= 0) begin
        if (gen && $urandom_range(0, 2) == 0) newreq(own);
        else rq[own] = 1'b0;
        own = -1;
      end
      for (int i = 0; i < N; i++) begin
        if (i == own) begin
          if ($urandom_range(0, 7) == 0) rq[i] = 1'b0;   // drop while granted
        end else if (!rq[i]) begin
          if (gen && $urandom_range(0, 3) == 0) newreq(i);
        end else if ($urandom_range(0, 15) == 0) begin
          rq[i] = 1'b0;                                   // withdraw before grant
        end
      end
      if (t == free_at) begin
        w = -1;
        for (int j = 0; j < N; j++) begin
          idx = (mrr + j) % N;
          if (w < 0 && rq[idx]) w = idx;
        end
        if (w < 0) begin
          free_at = t + 1;
        end else begin
          own = w;
          gq.push_back('{w, ra[w], rwd[w], rwr[w]});
          r = $urandom_range(0, 9);
          if (r == 0) begin
            db2_at  = -1;
            free_at = t + 2 + TMO;
            cq.push_back('{w, 1'b1, last_rd});
            mrr = (w + 1) % N;
          end else begin
            k       = (r == 1) ? TMO : $urandom_range(0, 4);
            db2_at  = t + 1 + k;
            din_exp = 12'($urandom);
            if (r == 2 && k > 0) begin
              clear_at = t + 1 + $urandom_range(0, k - 1);
              free_at  = clear_at + 1;
              db2_at   = -1;
              mrr      = 0;
              last_rd  = '0;
            end else begin
              free_at = t + 3 + k;
              rd      = rwr[w] ? last_rd : din_exp;
              last_rd = rd;
              cq.push_back('{w, 1'b0, rd});
              mrr = (w + 1) % N;
            end
          end
        end
      end
      s = $urandom_range(0, 31);
      if (s == int'(DB2C)) s = s + 1;
      state  = (t == db2_at) ? DB2C : 5'(s);
      dmaDIN = (db2_at >= 0 && (t == db2_at || t == db2_at + 1)) ? din_exp : 12'($urandom);
      clear  = (t == clear_at);
      drive_bus();
      @(negedge clk);
    end
    chk("drain_grants", 32'(gq.size()), 0);
    chk("drain_completions", 32'(cq.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Monitor: pops expectations whenever the DUT presents a grant or completion
  initial begin
    logic [N-1:0] prev_gnt;
    gnt_t g;
    cmp_t c;
    prev_gnt = '0;
    forever begin
      @(negedge clk);
      chk("at_most_one_hot", 32'(($countones(bus.gnt) <= 1) && ($countones(bus.done) <= 1) &&
          ($countones(bus.error) <= 1) && ((bus.done & bus.error) == '0)), 1);
      if (bus.gnt != '0 && prev_gnt == '0) begin
        if (gq.size() == 0) begin
          chk("grant_unexpected", 32'(bus.gnt), 0);
        end else begin
          g = gq.pop_front();
          chk("gnt", 32'(bus.gnt), 32'(1) << g.id);
          chk("gnt_dmaAddr", 32'(dmaAddr), 32'(g.a));
          chk("gnt_dmaDOUT", 32'(dmaDOUT), 32'(g.d));
          chk("gnt_to_disk", 32'(to_disk), 32'(g.w));
          chk("gnt_data_break", 32'(data_break), 1);
        end
      end
      if (bus.done != '0 || bus.error != '0) begin
        if (cq.size() == 0) begin
          chk("completion_unexpected", 32'({bus.done, bus.error}), 0);
        end else begin
          c = cq.pop_front();
          chk("done", 32'(bus.done), c.err ? 0 : (32'(1) << c.id));
          chk("error", 32'(bus.error), c.err ? (32'(1) << c.id) : 0);
          chk("rdata", 32'(bus.rdata), 32'(c.rd));
          chk("cmp_data_break", 32'(data_break), 0);
          chk("cmp_gnt", 32'(bus.gnt), 0);
          if (!c.err) chk("cmp_to_disk", 32'(to_disk), 0);
        end
      end
      prev_gnt = bus.gnt;
    end
  end

endmodule
